// File: rtl/amo_sequencer_if.sv
// Data-memory request/grant port between the atomic sequencer (master)
// and the data memory (slave).
interface amo_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: runs LR/SC/AMO read-modify-write over a
// request/grant memory port, borrowing the shared ALU for the modify step.
module amo_sequencer (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4:0]             funct5,
  input  logic [31:0]            addr,
  input  logic [31:0]            rs2_data,
  input  logic                   resv_clear,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            rd_data,
  amo_sequencer_if.master        mem,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_opt,
  input  logic [31:0]            alu_out
);
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  localparam logic [3:0] OPT_ADD = 4'b0000;
  localparam logic [3:0] OPT_XOR = 4'b0100;
  localparam logic [3:0] OPT_OR  = 4'b0110;
  localparam logic [3:0] OPT_AND = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_EXEC, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_t;

  state_t      state_reg, state_next;

  logic [4:0]  op_reg;
  logic [31:0] rs2_reg;
  logic [31:0] old_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rd_data_reg;
  logic        err_reg;
  logic        resv_valid_reg;
  logic [29:0] resv_addr_reg;

  logic        legal;
  logic        bad;
  logic        is_lr;
  logic        is_sc;
  logic        sc_ok;
  logic        signed_lt;
  logic        unsigned_lt;
  logic [31:0] new_val;

  always_comb begin
    legal = 1'b0;
    case (funct5)
      F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
      F_MIN, F_MAX, F_MINU, F_MAXU: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  end

  assign bad   = !legal || (addr[1:0] != 2'b00);
  assign is_lr = (funct5 == F_LR);
  assign is_sc = (funct5 == F_SC);
  // A clear arriving alongside the SC beats the reservation it would have used.
  assign sc_ok = resv_valid_reg && (resv_addr_reg == addr[31:2]) && !resv_clear;

  assign signed_lt   = $signed(old_reg) < $signed(rs2_reg);
  assign unsigned_lt = old_reg < rs2_reg;

  always_comb begin
    new_val = alu_out;
    case (op_reg)
      F_SWAP:  new_val = rs2_reg;
      F_MIN:   new_val = signed_lt   ? old_reg : rs2_reg;
      F_MAX:   new_val = signed_lt   ? rs2_reg : old_reg;
      F_MINU:  new_val = unsigned_lt ? old_reg : rs2_reg;
      F_MAXU:  new_val = unsigned_lt ? rs2_reg : old_reg;
      default: new_val = alu_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (bad)        state_next = S_DONE;
          else if (is_lr) state_next = S_RD_REQ;
          else if (is_sc) state_next = sc_ok ? S_WR_REQ : S_DONE;
          else            state_next = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (mem.mem_gnt)    state_next = S_RD_WAIT;
      S_RD_WAIT: if (mem.mem_rvalid) state_next = (op_reg == F_LR) ? S_DONE : S_EXEC;
      S_EXEC:                        state_next = S_WR_REQ;
      S_WR_REQ:  if (mem.mem_gnt)    state_next = S_WR_WAIT;
      S_WR_WAIT: if (mem.mem_rvalid) state_next = S_DONE;
      S_DONE:                        state_next = S_IDLE;
      default:                       state_next = S_IDLE;
    endcase
  end

  // Request strobes are state-decoded so reset drops them without waiting for a clock.
  always_comb begin
    busy        = (state_reg != S_IDLE);
    done        = (state_reg == S_DONE);
    mem.mem_req = (state_reg == S_RD_REQ) || (state_reg == S_WR_REQ);
    mem.mem_we  = (state_reg == S_WR_REQ);
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_opt     = OPT_ADD;
    if (state_reg == S_EXEC) begin
      alu_a = old_reg;
      alu_b = rs2_reg;
      case (op_reg)
        F_XOR:   alu_opt = OPT_XOR;
        F_OR:    alu_opt = OPT_OR;
        F_AND:   alu_opt = OPT_AND;
        default: alu_opt = OPT_ADD;
      endcase
    end
  end

  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign rd_data       = rd_data_reg;
  assign err           = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg      <= 5'd0;
      rs2_reg     <= 32'd0;
      old_reg     <= 32'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      rd_data_reg <= 32'd0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg      <= funct5;
            rs2_reg     <= rs2_data;
            addr_reg    <= {addr[31:2], 2'b00};
            wdata_reg   <= rs2_data;
            err_reg     <= bad;
            rd_data_reg <= (!bad && is_sc && !sc_ok) ? 32'd1 : 32'd0;
          end
        end
        S_RD_WAIT: begin
          if (mem.mem_rvalid) begin
            old_reg <= mem.mem_rdata;
            if (op_reg == F_LR) rd_data_reg <= mem.mem_rdata;
          end
        end
        S_EXEC: wdata_reg <= new_val;
        S_WR_WAIT: begin
          if (mem.mem_rvalid) rd_data_reg <= (op_reg == F_SC) ? 32'd0 : old_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resv_valid_reg <= 1'b0;
      resv_addr_reg  <= 30'd0;
    end else if (resv_clear) begin
      resv_valid_reg <= 1'b0;
    end else if ((state_reg == S_IDLE) && start && is_sc) begin
      resv_valid_reg <= 1'b0;
    end else if ((state_reg == S_RD_WAIT) && mem.mem_rvalid && (op_reg == F_LR)) begin
      resv_valid_reg <= 1'b1;
      resv_addr_reg  <= addr_reg[31:2];
    end
  end
endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: driver pushes expected responses and writes,
// a monitor and a memory responder pop and compare them.
module tb_amo_sequencer;
  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  funct5 = 5'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        resv_clear = 1'b0;
  logic        busy, done, err;
  logic [31:0] rd_data;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_opt;

  amo_sequencer_if mem_bus();

  amo_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct5     (funct5),
    .addr       (addr),
    .rs2_data   (rs2_data),
    .resv_clear (resv_clear),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_data    (rd_data),
    .mem        (mem_bus.master),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opt    (alu_opt),
    .alu_out    (alu_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU as seen by the core
  always_comb begin
    alu_out = 32'd0;
    case (alu_opt)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0100: alu_out = alu_a ^ alu_b;
      4'b0110: alu_out = alu_a | alu_b;
      4'b0111: alu_out = alu_a & alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  int   nvec = 0;
  int   nfail = 0;
  rsp_t exp_q[$];
  wr_t  wr_q[$];

  logic [31:0] mem_model [logic [29:0]];
  int rd_gnt_dly = 0, rd_rv_dly = 0, wr_gnt_dly = 0, wr_rv_dly = 0;
  int req_count = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end else begin
      $display("%s: %h ok", name, got);
    end
  endtask

  // Memory responder with programmable grant and response delays
  initial begin : responder
    logic        in_req, cap_we, stable, rv_pend;
    logic [31:0] cap_addr, cap_wd, rv_data;
    int          gcnt, rv_cnt, gdly;
    wr_t         w;
    in_req = 0; cap_we = 0; stable = 1; rv_pend = 0;
    cap_addr = 0; cap_wd = 0; rv_data = 0; gcnt = 0; rv_cnt = 0;
    mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_bus.mem_gnt = 0;
      mem_bus.mem_rvalid = 0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_bus.mem_rvalid = 1;
          mem_bus.mem_rdata = rv_data;
          rv_pend = 0;
        end else begin
          rv_cnt--;
        end
      end else if (mem_bus.mem_req) begin
        if (!in_req) begin
          in_req = 1; stable = 1; gcnt = 0;
          cap_addr = mem_bus.mem_addr; cap_we = mem_bus.mem_we; cap_wd = mem_bus.mem_wdata;
        end else if (mem_bus.mem_addr !== cap_addr || mem_bus.mem_we !== cap_we ||
                     mem_bus.mem_wdata !== cap_wd) begin
          stable = 0;
        end
        gdly = cap_we ? wr_gnt_dly : rd_gnt_dly;
        if (gcnt < gdly) begin
          gcnt++;
        end else begin
          mem_bus.mem_gnt = 1;
          in_req = 0;
          req_count++;
          chk("req_stable", 32'(stable), 32'd1);
          if (cap_we) begin
            mem_model[cap_addr[31:2]] = cap_wd;
            rv_data = 32'd0;
            rv_cnt = wr_rv_dly;
            nvec++;
            if (wr_q.size() == 0) begin
              nfail++;
              $display("FAIL unexpected_write: got write %h to %h, required no write", cap_wd, cap_addr);
            end else begin
              w = wr_q.pop_front();
              if (cap_addr !== w.a || cap_wd !== w.d) begin
                nfail++;
                $display("FAIL write: got %h to %h, required %h to %h", cap_wd, cap_addr, w.d, w.a);
              end else begin
                $display("write: %h to %h ok", cap_wd, cap_addr);
              end
            end
          end else begin
            rv_data = mem_model.exists(cap_addr[31:2]) ? mem_model[cap_addr[31:2]] : 32'd0;
            rv_cnt = rd_rv_dly;
          end
          rv_pend = 1;
        end
      end else begin
        in_req = 0;
      end
    end
  end

  // Response monitor: every done pulse pops one expected response
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
        end else begin
          e = exp_q.pop_front();
          if (err !== e.err || cyc != e.cyc || (!e.err && rd_data !== e.rd)) begin
            nfail++;
            $display("FAIL %s: got rd_data=%h err=%b cycle=%0d, required rd_data=%h err=%b cycle=%0d",
                     e.name, rd_data, err, cyc, e.rd, e.err, e.cyc);
          end else begin
            $display("%s: rd_data=%h err=%b cycle=%0d ok", e.name, rd_data, err, cyc);
          end
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [4:0] f5, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_k, input int exp_reqs, input logic exp_wr,
                        input logic [31:0] exp_wdata, input int exec_cyc,
                        input logic [3:0] exp_opt, input logic [31:0] exp_alu_a);
    int t0, r0, n;
    @(negedge clk);
    funct5 = f5; addr = a; rs2_data = d; start = 1;
    t0 = cyc; r0 = req_count;
    exp_q.push_back('{name, exp_rd, exp_err, t0 + exp_k});
    if (exp_wr) wr_q.push_back('{{a[31:2], 2'b00}, exp_wdata});
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done && n < 100) begin
      if (exec_cyc != 0 && cyc - t0 == exec_cyc) begin
        chk({name, "_alu_opt"}, 32'(alu_opt), 32'(exp_opt));
        chk({name, "_alu_a"}, alu_a, exp_alu_a);
        chk({name, "_alu_b"}, alu_b, d);
      end
      @(negedge clk);
      n++;
    end
    if (!done) begin
      nvec++; nfail++;
      $display("FAIL %s_timeout: got no done in 100 cycles, required done in cycle %0d", name, exp_k);
      exp_q.delete();
    end
    @(negedge clk);
    chk({name, "_idle_after"}, 32'({busy, done}), 32'd0);
    chk({name, "_mem_reqs"}, 32'(req_count - r0), 32'(exp_reqs));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int   t0;
    logic saw;
    mem_model[30'(32'h100 >> 2)] = 32'd5;
    mem_model[30'(32'h104 >> 2)] = 32'hFFFF_FFFF;
    mem_model[30'(32'h108 >> 2)] = 32'hFFFF_FFFF;
    mem_model[30'(32'h10C >> 2)] = 32'h0000_F0F0;
    mem_model[30'(32'h110 >> 2)] = 32'h8000_0000;
    mem_model[30'(32'h114 >> 2)] = 32'h8000_0000;
    mem_model[30'(32'h118 >> 2)] = 32'hFF00_FF00;
    mem_model[30'(32'h11C >> 2)] = 32'h0000_1234;
    mem_model[30'(32'h200 >> 2)] = 32'h0000_0055;
    mem_model[30'(32'h300 >> 2)] = 32'h0000_0077;
    mem_model[30'(32'h304 >> 2)] = 32'd1;

    repeat (3) @(negedge clk);
    chk("rst_busy_done_err", 32'({busy, done, err}), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_mem_req_we", 32'({mem_bus.mem_req, mem_bus.mem_we}), 32'd0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    chk("rst_alu", alu_a | alu_b | 32'(alu_opt), 32'd0);
    reset = 0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    //     name        f5        addr      rs2           rd            err k  rq wr wdata         ex opt      alu_a
    run_op("amoadd",   5'b00000, 32'h100, 32'd7,        32'd5,        0, 6, 2, 1, 32'd12,       3, 4'b0000, 32'd5);
    run_op("amomin",   5'b10000, 32'h104, 32'd1,        32'hFFFFFFFF, 0, 6, 2, 1, 32'hFFFFFFFF, 0, 4'b0000, 32'd0);
    run_op("amominu",  5'b11000, 32'h108, 32'd1,        32'hFFFFFFFF, 0, 6, 2, 1, 32'd1,        0, 4'b0000, 32'd0);
    run_op("amomax",   5'b10100, 32'h110, 32'd5,        32'h80000000, 0, 6, 2, 1, 32'd5,        0, 4'b0000, 32'd0);
    run_op("amomaxu",  5'b11100, 32'h114, 32'd5,        32'h80000000, 0, 6, 2, 1, 32'h80000000, 0, 4'b0000, 32'd0);
    run_op("amoand",   5'b01100, 32'h118, 32'h0FF00FF0, 32'hFF00FF00, 0, 6, 2, 1, 32'h0F000F00, 3, 4'b0111, 32'hFF00FF00);
    run_op("amoor",    5'b01000, 32'h118, 32'h000000FF, 32'h0F000F00, 0, 6, 2, 1, 32'h0F000FFF, 3, 4'b0110, 32'h0F000F00);
    run_op("amoswap",  5'b00001, 32'h11C, 32'hDEAD,     32'h1234,     0, 6, 2, 1, 32'hDEAD,     0, 4'b0000, 32'd0);
    run_op("lr",       5'b00010, 32'h200, 32'd0,        32'h55,       0, 3, 1, 0, 32'd0,        0, 4'b0000, 32'd0);
    run_op("sc_ok",    5'b00011, 32'h200, 32'hAB,       32'd0,        0, 3, 1, 1, 32'hAB,       0, 4'b0000, 32'd0);
    run_op("sc_again", 5'b00011, 32'h200, 32'hCD,       32'd1,        0, 1, 0, 0, 32'd0,        0, 4'b0000, 32'd0);
    run_op("lr2",      5'b00010, 32'h200, 32'd0,        32'hAB,       0, 3, 1, 0, 32'd0,        0, 4'b0000, 32'd0);
    @(negedge clk); resv_clear = 1;
    @(negedge clk); resv_clear = 0;
    run_op("sc_clrd",  5'b00011, 32'h200, 32'hEE,       32'd1,        0, 1, 0, 0, 32'd0,        0, 4'b0000, 32'd0);
    run_op("lr3",      5'b00010, 32'h200, 32'd0,        32'hAB,       0, 3, 1, 0, 32'd0,        0, 4'b0000, 32'd0);
    run_op("sc_other", 5'b00011, 32'h204, 32'hEE,       32'd1,        0, 1, 0, 0, 32'd0,        0, 4'b0000, 32'd0);
    run_op("lr4",      5'b00010, 32'h200, 32'd0,        32'hAB,       0, 3, 1, 0, 32'd0,        0, 4'b0000, 32'd0);
    run_op("amo_mid",  5'b00000, 32'h100, 32'd1,        32'd12,       0, 6, 2, 1, 32'd13,       0, 4'b0000, 32'd0);
    run_op("sc_keep",  5'b00011, 32'h200, 32'h11,       32'd0,        0, 3, 1, 1, 32'h11,       0, 4'b0000, 32'd0);
    run_op("misalign", 5'b00001, 32'h102, 32'd3,        32'd0,        1, 1, 0, 0, 32'd0,        0, 4'b0000, 32'd0);
    run_op("illegal",  5'b00101, 32'h100, 32'd3,        32'd0,        1, 1, 0, 0, 32'd0,        0, 4'b0000, 32'd0);

    rd_gnt_dly = 3; wr_rv_dly = 2;
    run_op("amoxor_st",5'b00100, 32'h10C, 32'h0FF0,     32'hF0F0,     0, 11, 2, 1, 32'hFF00,    6, 4'b0100, 32'hF0F0);
    rd_gnt_dly = 0; wr_rv_dly = 0;

    run_op("lr5",      5'b00010, 32'h300, 32'd0,        32'h77,       0, 3, 1, 0, 32'd0,        0, 4'b0000, 32'd0);

    // Reset while the write acknowledge of an AMO is outstanding
    wr_rv_dly = 4;
    @(negedge clk);
    funct5 = 5'b00000; addr = 32'h304; rs2_data = 32'd2; start = 1;
    t0 = cyc;
    wr_q.push_back('{32'h304, 32'd3});
    @(negedge clk);
    start = 0;
    while (cyc - t0 < 6) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 reset = 1;
    #1;
    chk("reset_async_busy_req", 32'({busy, mem_bus.mem_req}), 32'd0);
    @(negedge clk);
    reset = 0;
    wr_rv_dly = 0;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    chk("no_done_after_reset", 32'(saw), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);
    run_op("sc_post_rst", 5'b00011, 32'h300, 32'h99, 32'd1,        0, 1, 0, 0, 32'd0,        0, 4'b0000, 32'd0);

    chk("pending_responses", 32'(exp_q.size()), 32'd0);
    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/amo_sequencer.md
# amo_sequencer

Multi-cycle sequencer for RV32A atomic instructions (LR.W, SC.W, AMO*.W) in the RV32IA core. It accepts one atomic operation from the decode/execute stage and runs the read–modify–write sequence over a request/grant data-memory port. It borrows the shared ALU for the ADD/XOR/AND/OR modify step and performs the MIN/MAX comparisons locally. It also holds the single LR/SC reservation.

## Interface
Parameters: none (RV32 fixed, XLEN = 32).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch an operation; sampled only in IDLE
- funct5  in  5  RV32A funct5 (instr[31:27])
- addr  in  32  effective address (rs1)
- rs2_data  in  32  operand / store data
- resv_clear  in  1  kill reservation (trap, context switch)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; misaligned address or illegal funct5
- rd_data  out  32  valid with done; written back to rd
- mem_req  out  1  memory request, held until granted
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data / write acknowledge; arrives ≥1 cycle after mem_gnt
- mem_rdata  in  32  read data, valid with mem_rvalid
- alu_a, alu_b  out  32  ALU operands
- alu_opt  out  4  ALU operation
- alu_out  in  32  combinational ALU result

## Operation
- funct5 codes: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100. Any other code is illegal.
- alu_opt codes: ADD 4'b0000, XOR 4'b0100, OR 4'b0110, AND 4'b0111.
- States: IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ, WR_WAIT, DONE.
- IDLE + start:
  - addr[1:0]≠0 or illegal funct5 → DONE with err=1 and no memory access.
  - LR → RD_REQ.
  - SC with reservation valid and resv_addr==addr[31:2] and resv_clear=0 → WR_REQ.
  - SC otherwise → DONE, rd_data=1, no write.
  - AMO → RD_REQ.
- RD_REQ: mem_req=1, mem_we=0. On mem_gnt → RD_WAIT.
- RD_WAIT: on mem_rvalid, latch old=mem_rdata.
  - LR: set the reservation to addr[31:2] (resv_clear the same cycle wins) → DONE, rd_data=old.
  - AMO → EXEC.
- EXEC (1 cycle): alu_a=old, alu_b=rs2_data, alu_opt per funct5. Latch new into mem_wdata:
  - ADD/XOR/OR/AND: alu_out.
  - SWAP: rs2_data.
  - MIN/MAX: signed local compare of old vs rs2_data.
  - MINU/MAXU: unsigned local compare.
  - Then → WR_REQ.
- WR_REQ: mem_req=1, mem_we=1. On mem_gnt → WR_WAIT.
- WR_WAIT: on mem_rvalid → DONE.
  - SC: rd_data=0.
  - AMO: rd_data=old.
- DONE: done=1 for one cycle → IDLE.
- Reservation:
  - Cleared by every SC (success or fail), by resv_clear in any state, and by reset.
  - AMOs do not touch it.
- mem_rvalid is ignored in IDLE, RD_REQ, WR_REQ, EXEC and DONE. mem_gnt is ignored outside the REQ states.
- start while busy is ignored (no queueing).
- alu_a, alu_b and alu_opt are 0 outside EXEC.

## Timing
- All outputs are registered or state-decoded; no combinational path from mem inputs to mem outputs.
- Reset value of every output is 0; state=IDLE, reservation invalid.
- Reset mid-operation:
  - mem_req drops asynchronously and the operation is abandoned with no done.
  - A late mem_rvalid after reset is discarded.
- Zero-wait memory latencies (gnt in the request cycle, rvalid the next cycle), start sampled at edge 0:
  - AMO: done high in cycle 6.
  - LR: done in cycle 3.
  - SC success: done in cycle 3.
  - SC fail or err: done in cycle 1.
- Each extra cycle of mem_gnt or mem_rvalid wait adds exactly one cycle.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and ungranted.
- busy rises the cycle after start is accepted and falls the cycle after done.
- A new start is accepted in the cycle busy=0.

## Test plan
- AMOADD: mem[0x100]=5, rs2=7, zero-wait → write 12 to 0x100; rd_data=5, done in cycle 6; alu_opt=0000 during EXEC.
- AMOMIN vs AMOMINU: old=0xFFFFFFFF, rs2=1 → MIN writes 0xFFFFFFFF; MINU writes 1; both return rd_data=0xFFFFFFFF.
- LR 0x200, then SC 0x200 rs2=0xAB → write 0xAB, rd_data=0. A second SC to 0x200 → no mem_req, rd_data=1.
- LR 0x200, pulse resv_clear, then SC 0x200 → fail, rd_data=1. LR 0x200 then SC 0x204 → fail.
- addr=0x102 AMOSWAP, and funct5=00101 → done in cycle 1 with err=1 and mem_req never asserted.
- AMOXOR with 3-cycle gnt stall and 2-cycle rvalid delay → request signals stable throughout; done in cycle 11.
- Reset asserted in WR_WAIT, then a late mem_rvalid → no done, IDLE, reservation invalid.
